// File: rtl/sat_sched_pkg.sv
// Shared types and constant helpers for the sat_sched requantizing scheduler.
package sat_sched_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ost_e;

  // Largest positive two's-complement code of width w: {0, 1...1}
  function automatic logic [63:0] sat_hi_f(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement code of width w: {1, 0...0}
  function automatic logic [63:0] sat_lo_f(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  input  logic           en,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  idx
);

  int          j;
  logic [PW-1:0] k;
  logic        found;

  // Scan from ptr upward, taking the first active request
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    k     = '0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(ptr) + i;
      if (j >= NCH) j = j - NCH;
      k = PW'(j);
      if (en && !found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/sat_sched.sv
// Round-robin scheduler feeding one shared saturating requantizer with a
// single-entry output register and per-channel saturation counters.
// Optional build macro: SAT_SCHED_ROUND_EN (round half-up before truncation).
module sat_sched
  import sat_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int M_I   = 2,
  parameter int N_I   = 24,
  parameter int M_O   = 1,
  parameter int N_O   = 20,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NCH-1:0]             req_valid_i,
  input  logic [NCH*(M_I+N_I)-1:0]   req_data_i,
  output logic [NCH-1:0]             req_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [M_O+N_O-1:0]         out_data_o,
  output logic [$clog2(NCH)-1:0]     out_ch_o,
  output logic                       out_sat_o,
  input  logic                       clr_cnt_i,
  output logic [NCH*CNT_W-1:0]       sat_cnt_o
);

  localparam int IW = M_I + N_I;
  localparam int OW = M_O + N_O;
  localparam int PW = $clog2(NCH);
`ifdef SAT_SCHED_ROUND_EN
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] RND = SW'(1) << (N_I - N_O - 1);
`else
  localparam int SW = IW;
`endif
  localparam logic [OW-1:0] SAT_HI = OW'(sat_hi_f(OW));
  localparam logic [OW-1:0] SAT_LO = OW'(sat_lo_f(OW));

  ost_e                  state;
  logic [PW-1:0]         ptr;
  logic                  load;
  logic                  en;
  logic                  xfer;
  logic [NCH-1:0]        grant;
  logic [PW-1:0]         gidx;
  logic signed [IW-1:0]  sample;
  logic signed [SW-1:0]  ext;
  logic [SW-N_I-M_O:0]   top;
  logic [OW-1:0]         q_res;
  logic                  q_sat;
  logic                  unused_lsb;
  logic [CNT_W-1:0]      cnt [NCH];

  assign out_valid_o = (state == ST_FULL);
  assign load        = !out_valid_o || out_ready_i;
  assign en          = load && !rst_i;
  assign xfer        = |grant;
  assign req_ready_o = grant;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .en    (en),
    .grant (grant),
    .idx   (gidx)
  );

  // One-hot mux of the granted channel's sample
  always_comb begin
    sample = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) sample = req_data_i[i*IW +: IW];
  end

`ifdef SAT_SCHED_ROUND_EN
  assign ext = {sample[IW-1], sample} + RND;
`else
  assign ext = sample;
`endif
  assign top        = ext[SW-1:N_I+M_O-1];
  assign unused_lsb = ^ext[N_I-N_O-1:0];

  // Range check on the discarded integer bits, saturate on overflow
  always_comb begin
    q_res = ext[N_I+M_O-1:N_I-N_O];
    q_sat = 1'b0;
    if (!((&top) || !(|top))) begin
      q_sat = 1'b1;
      q_res = ext[SW-1] ? SAT_LO : SAT_HI;
    end
  end

  // Output register and pointer: load on transfer, empty on drain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_EMPTY;
      out_data_o <= '0;
      out_ch_o   <= '0;
      out_sat_o  <= 1'b0;
      ptr        <= '0;
    end else if (xfer) begin
      state      <= ST_FULL;
      out_data_o <= q_res;
      out_ch_o   <= gidx;
      out_sat_o  <= q_sat;
      ptr        <= (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
    end else if (out_ready_i) begin
      state      <= ST_EMPTY;
    end
  end

  // Sticky saturation counters; clear beats a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (clr_cnt_i) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (xfer && q_sat && (cnt[gidx] != {CNT_W{1'b1}})) begin
      cnt[gidx] <= cnt[gidx] + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    assign sat_cnt_o[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_sat_sched.sv
// Scoreboard bench for sat_sched with Q4.12 -> Q1.8, 4 channels, 2-bit counters.
module tb_sat_sched;

  localparam int NCH = 4, M_I = 4, N_I = 12, M_O = 1, N_O = 8, CNT_W = 2;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   req_valid_i;
  logic [63:0]  req_data_i;
  logic [3:0]   req_ready_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [8:0]   out_data_o;
  logic [1:0]   out_ch_o;
  logic         out_sat_o;
  logic         clr_cnt_i;
  logic [7:0]   sat_cnt_o;

  sat_sched #(.NCH(NCH), .M_I(M_I), .N_I(N_I), .M_O(M_O), .N_O(N_O), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o),
    .out_sat_o   (out_sat_o),
    .clr_cnt_i   (clr_cnt_i),
    .sat_cnt_o   (sat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [8:0] d;
    logic       s;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] m_ptr;
  logic       m_full;
  logic [1:0] m_cnt [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference requantizer in plain integer arithmetic
  task automatic model_q(input logic [15:0] din, output logic [8:0] q, output logic s);
    int v;
    v = int'($signed(din));
`ifdef SAT_SCHED_ROUND_EN
    v = v + 8;
`endif
    v = v >>> 4;
    s = 1'b0;
    if (v > 255) begin
      q = 9'h0FF; s = 1'b1;
    end else if (v < -256) begin
      q = 9'h100; s = 1'b1;
    end else begin
      q = v[8:0];
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [63:0] d);
    req_valid_i = v;
    req_data_i  = d;
  endtask

  task automatic model_reset();
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 2'd0;
  endtask

  // One clock: check DUT against model at negedge, then advance model
  task automatic step();
    logic [3:0] g;
    int         gi;
    int         j;
    exp_t       e;
    logic [8:0] q;
    logic       s;
    @(negedge clk);
    g  = '0;
    gi = -1;
    if ((!m_full || out_ready_i) && !rst_i) begin
      for (int i = 0; i < 4; i++) begin
        j = (int'(m_ptr) + i) % 4;
        if (gi < 0 && req_valid_i[j]) begin
          gi   = j;
          g[j] = 1'b1;
        end
      end
    end
    chk("req_ready", req_ready_o, g);
    chk("out_valid", out_valid_o, m_full);
    if (m_full) begin
      if (sb.size() > 0) begin
        e = sb[0];
        chk("out_data", out_data_o, e.d);
        chk("out_ch", out_ch_o, e.ch);
        chk("out_sat", out_sat_o, e.s);
        if (out_ready_i) void'(sb.pop_front());
      end else begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("sat_cnt%0d", i), sat_cnt_o[i*2 +: 2], m_cnt[i]);
    if (gi >= 0) begin
      model_q(req_data_i[gi*16 +: 16], q, s);
      e.ch = gi[1:0];
      e.d  = q;
      e.s  = s;
      sb.push_back(e);
      m_ptr  = gi[1:0] + 2'd1;
      m_full = 1'b1;
      if (s && m_cnt[gi] != 2'b11) m_cnt[gi] = m_cnt[gi] + 2'd1;
    end else if (out_ready_i) begin
      m_full = 1'b0;
    end
    if (clr_cnt_i) for (int i = 0; i < 4; i++) m_cnt[i] = 2'd0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rvals [4];

  initial begin
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    clr_cnt_i   = 1'b0;
    drive(4'h0, 64'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", out_data_o, 0);
    chk("rst_ch", out_ch_o, 0);
    chk("rst_sat", out_sat_o, 0);
    step();
    rst_i = 1'b0;

    // in-range truncation on ch0
    drive(4'b0001, 64'h0800); step();
    drive(4'b0000, 64'h0);    step();
    drive(4'b0001, 64'hF000); step();
    drive(4'b0000, 64'h0);    step();
    // overflow on ch1, underflow on ch2
    drive(4'b0010, 64'h1000 << 16); step();
    drive(4'b0000, 64'h0);          step();
    drive(4'b0100, 64'hE000 << 32); step();
    drive(4'b0000, 64'h0);          step();

    // fairness with all requesters active
    repeat (12) begin drive(4'hF, {$urandom, $urandom}); step(); end
    // backpressure while FULL, then release
    out_ready_i = 1'b0;
    repeat (3) begin drive(4'hF, {$urandom, $urandom}); step(); end
    out_ready_i = 1'b1;
    repeat (5) begin drive(4'hF, {$urandom, $urandom}); step(); end
    drive(4'h0, 64'h0); step(); step();

    // counter saturation on ch3, then clear against a saturating transfer
    repeat (5) begin drive(4'b1000, 64'h7000 << 48); step(); end
    clr_cnt_i = 1'b1; step();
    clr_cnt_i = 1'b0;
    drive(4'h0, 64'h0); step(); step();

    // rounding-sensitive codes on ch0
    rvals[0] = 16'h0808; rvals[1] = 16'h0FF8; rvals[2] = 16'h0807; rvals[3] = 16'h7FFF;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, {48'h0, rvals[i]}); step();
      drive(4'b0000, 64'h0);             step();
    end

    // async reset in the middle of a burst
    repeat (6) begin drive(4'hF, {$urandom, $urandom}); step(); end
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_data", out_data_o, 0);
    chk("arst_ch", out_ch_o, 0);
    chk("arst_sat", out_sat_o, 0);
    chk("arst_ready", req_ready_o, 0);
    chk("arst_cnt", sat_cnt_o, 0);
    model_reset();
    step();
    rst_i = 1'b0;
    repeat (6) begin drive(4'hF, {$urandom, $urandom}); step(); end
    drive(4'h0, 64'h0); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
